// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the sequencing controller, its requester, its consumer and the ALU.
// The controller uses the slave modport. The requester/consumer/ALU side uses the master modport.
interface alu_seq_ctrl_if #(
   parameter int unsigned W = 8
);
   // command in
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   in_cmd;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   // ALU drive / return
   logic [2:0]   alu_op;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_y;
   logic         alu_n;
   logic         alu_v;
   logic         alu_c;
   logic         alu_z;
   // result out
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_lo;
   logic [W-1:0] out_hi;
   logic         out_err;
   // flag register
   logic         N;
   logic         V;
   logic         C;
   logic         Z;

   modport slave (
      input  in_valid, in_cmd, in_a, in_b, out_ready,
      input  alu_y, alu_n, alu_v, alu_c, alu_z,
      output in_ready, out_valid, out_lo, out_hi, out_err,
      output alu_op, alu_a, alu_b, N, V, C, Z
   );

   modport master (
      output in_valid, in_cmd, in_a, in_b, out_ready,
      output alu_y, alu_n, alu_v, alu_c, alu_z,
      input  in_ready, out_valid, out_lo, out_hi, out_err,
      input  alu_op, alu_a, alu_b, N, V, C, Z
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of a W-bit combinational ALU.
// It runs single ALU ops, and it runs a shift-add multiply that uses the ALU adder once per cycle.
// It registers the result and the N/V/C/Z flags.
// Optional feature macro: ALU_SEQ_MUL_EN builds the MUL command.
// When the macro is undefined, cmd 4'b1000 takes the illegal path.
module alu_seq_ctrl #(
   parameter int unsigned W = 8
) (
   input logic          CLK,
   input logic          RESET,
   alu_seq_ctrl_if.slave bus
);
   localparam int unsigned CW      = (W > 1) ? $clog2(W) : 1;
   localparam logic [3:0]  CMD_MUL = 4'b1000;

   typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

   state_e       state_q, state_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_lo_q, out_lo_d;
   logic [W-1:0] out_hi_q, out_hi_d;
   logic         out_err_q, out_err_d;
   logic [3:0]   flags_q, flags_d;          // {N,V,C,Z}
   logic [2:0]   alu_op_q, alu_op_d;
   logic [W-1:0] alu_a_q, alu_a_d;          // doubles as acc_hi while multiplying
   logic [W-1:0] alu_b_q, alu_b_d;          // doubles as multiplicand while multiplying
   logic         accept_c;
   logic         is_mul_c;

`ifdef ALU_SEQ_MUL_EN
   logic [W-1:0]  acc_lo_q, acc_lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  acc_hi_nxt, acc_lo_nxt;
   logic          mul_last_c;

   assign is_mul_c   = (bus.in_cmd == CMD_MUL);
   assign mul_last_c = (cnt_q == CW'(W - 1));
`else
   assign is_mul_c   = 1'b0;
`endif

   assign accept_c = bus.in_valid & in_ready_q;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (!bus.in_cmd[3]) state_d = EXEC;
               else if (is_mul_c)  state_d = MUL;
               else                state_d = DONE;
            end
         end
         EXEC: state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
         MUL:  if (mul_last_c) state_d = DONE;
`endif
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values; everything holds unless a state updates it
   always_comb begin
      out_lo_d  = out_lo_q;
      out_hi_d  = out_hi_q;
      out_err_d = out_err_q;
      flags_d   = flags_q;
      alu_op_d  = alu_op_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
`ifdef ALU_SEQ_MUL_EN
      acc_lo_d   = acc_lo_q;
      cnt_d      = cnt_q;
      acc_hi_nxt = alu_a_q;
      acc_lo_nxt = acc_lo_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               if (!bus.in_cmd[3]) begin
                  alu_op_d = bus.in_cmd[2:0];
                  alu_a_d  = bus.in_a;
                  alu_b_d  = bus.in_b;
               end else if (is_mul_c) begin
`ifdef ALU_SEQ_MUL_EN
                  alu_op_d = 3'b000;
                  alu_a_d  = '0;
                  alu_b_d  = bus.in_a;
                  acc_lo_d = bus.in_b;
                  cnt_d    = '0;
`endif
               end else begin
                  out_err_d = 1'b1;
                  out_lo_d  = '0;
                  out_hi_d  = '0;
               end
            end
         end
         EXEC: begin
            out_lo_d  = bus.alu_y;
            out_hi_d  = '0;
            out_err_d = 1'b0;
            flags_d   = {bus.alu_n, bus.alu_v, bus.alu_c, bus.alu_z};
         end
`ifdef ALU_SEQ_MUL_EN
         MUL: begin
            // One shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
            if (acc_lo_q[0]) begin
               acc_hi_nxt = {bus.alu_c, bus.alu_y[W-1:1]};
               acc_lo_nxt = {bus.alu_y[0], acc_lo_q[W-1:1]};
            end else begin
               acc_hi_nxt = {1'b0, alu_a_q[W-1:1]};
               acc_lo_nxt = {alu_a_q[0], acc_lo_q[W-1:1]};
            end
            alu_a_d  = acc_hi_nxt;
            acc_lo_d = acc_lo_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last_c) begin
               out_hi_d  = acc_hi_nxt;
               out_lo_d  = acc_lo_nxt;
               out_err_d = 1'b0;
               flags_d   = {acc_hi_nxt[W-1], 1'b0, |acc_hi_nxt, ~|{acc_hi_nxt, acc_lo_nxt}};
            end
         end
`endif
         default: ;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // Datapath and output registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_lo_q    <= '0;
         out_hi_q    <= '0;
         out_err_q   <= 1'b0;
         flags_q     <= '0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
`ifdef ALU_SEQ_MUL_EN
         acc_lo_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_lo_q    <= out_lo_d;
         out_hi_q    <= out_hi_d;
         out_err_q   <= out_err_d;
         flags_q     <= flags_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
`ifdef ALU_SEQ_MUL_EN
         acc_lo_q    <= acc_lo_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_lo    = out_lo_q;
   assign bus.out_hi    = out_hi_q;
   assign bus.out_err   = out_err_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign {bus.N, bus.V, bus.C, bus.Z} = flags_q;
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller placed in front of the 8-bit combinational ALU and flag stage.
- Accepts one command at a time on a valid/ready input and drives the ALU opcode and operands.
- Captures the ALU result and N/V/C/Z into a registered flag register, and returns the result on a valid/ready output.
- Also runs a multi-cycle MUL command: shift-add, reusing the ALU adder once per iteration.

Parameters:
- W, 8: datapath width. The ALU width must match. MUL runs W iterations and produces a 2W result.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  a command is presented.
- in_ready  out  1  controller can accept a command; high only in IDLE.
- in_cmd  in  4  bit 3 = 0: single ALU op, with bits [2:0] as the ALU OP; 4'b1000: MUL. Other values are illegal.
- in_a  in  W  operand A, or multiplicand for MUL.
- in_b  in  W  operand B, or multiplier for MUL.
- alu_op  out  3  opcode to the ALU.
- alu_a  out  W  ALU operand A.
- alu_b  out  W  ALU operand B.
- alu_y  in  W  ALU result.
- alu_n, alu_v, alu_c, alu_z  in  1 each  ALU flags.
- out_valid  out  1  a result is available.
- out_ready  in  1  consumer takes the result.
- out_lo  out  W  result, or low half of the product.
- out_hi  out  W  zero for single ops; high half of the product for MUL.
- out_err  out  1  command was illegal.
- N, V, C, Z  out  1 each  flag register; retains its value after the result is popped.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; out_lo=0; out_hi=0; out_err=0.
  - N=V=C=Z=0; alu_op=000; alu_a=0; alu_b=0.
  - Iteration counter = 0.
  - Reset mid-command aborts it with no output.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - A handshake (in_valid & in_ready) latches in_cmd, in_a and in_b.
  - in_cmd[3]=0 goes to EXEC. MUL goes to MUL with acc_hi=0, acc_lo=in_b and counter=0.
  - An illegal command goes directly to DONE with out_err=1, out_lo=0, out_hi=0, and flags unchanged.
- EXEC (1 cycle):
  - Drives alu_op=cmd[2:0], alu_a=a, alu_b=b.
  - At the clock edge: out_lo<=alu_y, out_hi<=0, {N,V,C,Z}<=ALU flags, then go to DONE.
- MUL (exactly W cycles):
  - Drives alu_op=000 (ADD), alu_a=acc_hi, alu_b=multiplicand.
  - If acc_lo[0]=1: {acc_hi,acc_lo} <= {alu_c, alu_y, acc_lo} >> 1.
  - If acc_lo[0]=0: {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo} >> 1, and the ALU result is ignored.
  - Counter increments each cycle. When the counter reaches W-1, go to DONE.
  - On entry to DONE: out_hi=acc_hi and out_lo=acc_lo (the final values).
  - Flags on entry to DONE: Z=(product==0); N=product[2W-1]; C=(out_hi!=0); V=0.
- DONE:
  - out_valid=1 and in_ready=0. Outputs hold stable while out_ready=0.
  - out_valid & out_ready returns to IDLE.
  - The next command is accepted no earlier than the cycle after the pop, so there is no overlap.
- Latency, counting cycles after the accept edge:
  - Single op: out_valid 2 cycles after the accept edge.
  - MUL: out_valid W+1 cycles after the accept edge.
  - Illegal command: out_valid 1 cycle after the accept edge.
- Outside EXEC and MUL, alu_op/alu_a/alu_b hold their last values. This bounds ALU toggling.
- A multiplicand or multiplier of 0 still takes the full W cycles (no early exit).
- in_valid asserted while in_ready=0 is ignored; the command is not lost only if the requester holds it.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined: the MUL state and accumulator are not built, and in_cmd=4'b1000 is handled as an illegal command (err path, 1-cycle latency, flags unchanged).

Test Plan:
- Single op, add overflow: cmd=0000, a=8'h7F, b=8'h01, bench ALU model → out_valid 2 cycles after accept; out_lo=8'h80, out_hi=0; N=1, V=1, C=0, Z=0.
- MUL, full range: cmd=1000, a=8'hFF, b=8'hFF → out_valid 9 cycles after accept; {out_hi,out_lo}=16'hFE01; C=1, N=1, Z=0, V=0.
- MUL, zero operand: a=8'h00, b=8'h37 → product 0, Z=1, C=0; still a 9-cycle latency.
- Backpressure: complete a single op with out_ready=0 for 5 cycles → out_valid and out_lo stable; in_ready=0 throughout; a second in_valid is not accepted until the cycle after the pop.
- Reset mid-MUL: assert RESET in the 4th MUL cycle → next edge gives IDLE, out_valid=0, flags=0; a new ADD of 3+4 then returns 8'h07.
- Illegal command: cmd=1011, or 1000 with ALU_SEQ_MUL_EN undefined → out_err=1, out_lo=0, out_valid 1 cycle after accept; N/V/C/Z keep their prior values.
